// File: rtl/bus_arbiter.sv
// Shares one Wishbone-style port between instruction fetch and load/store.
// Data has priority; results are held until the owning stage advances.
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        stallreq_if_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stallreq_mem_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IBUS = 2'd1;
  localparam logic [1:0] S_DBUS = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic        r_if_valid, r_mem_valid;
  logic [7:0]  r_cnt;
  logic        r_cyc, r_we, r_timeout;
  logic [3:0]  r_sel;
  logic [31:0] r_addr, r_wdata, r_if_rdata, r_mem_rdata;

  logic w_idle, w_busy, w_ack, w_to, w_done;
  logic w_issue_d, w_issue_i, w_deliver_if, w_deliver_mem;
  logic [31:0] w_result;
  logic w_unused;

  assign w_unused = ^{stall[5], stall[3:2], stall[0]};

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy   = ~w_idle;
  assign w_ack    = w_busy & bus_ack_i;
  // ack in the final allowed cycle still counts as a normal completion
  assign w_to     = w_busy & ~bus_ack_i & (r_cnt == TO_LAST);
  assign w_done   = w_ack | w_to;
  assign w_result = w_ack ? bus_rdata_i : 32'h0;

  assign w_issue_d     = w_idle & ~flush & mem_req_i & ~r_mem_valid;
  assign w_issue_i     = w_idle & ~flush & ~w_issue_d & if_req_i & ~r_if_valid;
  assign w_deliver_if  = (r_state == S_IBUS) & ~flush & w_done;
  assign w_deliver_mem = (r_state == S_DBUS) & ~flush & w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_cnt       <= 8'd0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= w_to;
      if (w_idle) begin
        if (w_issue_d) begin
          r_state <= S_DBUS;
          r_cyc   <= 1'b1;
          r_we    <= mem_we_i;
          r_sel   <= mem_sel_i;
          r_addr  <= mem_addr_i;
          r_wdata <= mem_wdata_i;
          r_cnt   <= 8'd0;
        end else if (w_issue_i) begin
          r_state <= S_IBUS;
          r_cyc   <= 1'b1;
          r_we    <= 1'b0;
          r_sel   <= 4'b1111;
          r_addr  <= if_addr_i;
          r_wdata <= 32'd0;
          r_cnt   <= 8'd0;
        end
      end else if (w_done) begin
        r_state <= S_IDLE;
        r_cyc   <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
        // a flushed transfer still runs to completion so stores take effect
        if (flush) r_state <= S_DROP;
      end

      if (w_deliver_if)  r_if_rdata  <= w_result;
      if (w_deliver_mem) r_mem_rdata <= w_result;

      if (flush)              r_if_valid <= 1'b0;
      else if (w_deliver_if)  r_if_valid <= 1'b1;
      else if (~stall[1])     r_if_valid <= 1'b0;

      if (flush)              r_mem_valid <= 1'b0;
      else if (w_deliver_mem) r_mem_valid <= 1'b1;
      else if (~stall[4])     r_mem_valid <= 1'b0;
    end
  end

  assign stallreq_if_o  = if_req_i & ~r_if_valid & ~flush;
  assign stallreq_mem_o = mem_req_i & ~r_mem_valid & ~flush;

  assign if_rdata_o    = r_if_rdata;
  assign mem_rdata_o   = r_mem_rdata;
  assign bus_cyc_o     = r_cyc;
  assign bus_stb_o     = r_cyc;
  assign bus_we_o      = r_we;
  assign bus_sel_o     = r_sel;
  assign bus_addr_o    = r_addr;
  assign bus_wdata_o   = r_wdata;
  assign bus_timeout_o = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario bench for bus_arbiter: directed cases plus random transfers checked
// against a transaction-level model (ack cycle vs timeout, delivered data).
module tb_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        stallreq_if_o;
  logic        mem_req_i, mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic        stallreq_mem_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i, bus_timeout_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_if_rd, m_mem_rd;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .stallreq_if_o(stallreq_if_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .stallreq_mem_o(stallreq_mem_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_timeout_o(bus_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // One complete transfer: request, bus phase, result, optional hold, consume.
  task automatic run_xfer(input bit is_mem, input bit we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_at, input int hold);
    bit tmo;
    int last;
    logic [31:0] exp_d;
    logic [3:0]  exp_sel;
    logic        exp_we, sreq;
    logic [31:0] got_d;
    tmo     = !(ack_at >= 1 && ack_at <= TO);
    last    = tmo ? TO : ack_at;
    exp_d   = tmo ? 32'h0 : rdata;
    exp_sel = is_mem ? sel : 4'hF;
    exp_we  = is_mem & we;
    stall = 6'b0;
    if (is_mem) begin
      mem_req_i = 1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_wdata_i = wdata;
    end else begin
      if_req_i = 1; if_addr_i = addr;
    end
    settle;
    sreq = is_mem ? stallreq_mem_o : stallreq_if_o;
    n_vec++;
    if ({sreq, bus_cyc_o} !== 2'b10) begin
      n_err++; $display("FAIL xfer_req: stallreq/cyc=%b expected 10", {sreq, bus_cyc_o});
    end
    for (int k = 1; k <= last; k++) begin
      tick;
      bus_ack_i   = (k == ack_at);
      bus_rdata_i = (k == ack_at) ? rdata : $urandom;
      settle;
      sreq = is_mem ? stallreq_mem_o : stallreq_if_o;
      n_vec++;
      if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, sreq, bus_timeout_o} !==
          {1'b1, 1'b1, exp_we, exp_sel, addr, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL xfer_bus k=%0d: cyc%b stb%b we%b sel%h addr%h sreq%b to%b expected we%b sel%h addr%h",
                 k, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, sreq, bus_timeout_o,
                 exp_we, exp_sel, addr);
      end
      if (exp_we) begin
        n_vec++;
        if (bus_wdata_o !== wdata) begin
          n_err++; $display("FAIL xfer_wdata: %h expected %h", bus_wdata_o, wdata);
        end
      end
    end
    tick;
    bus_ack_i = 0; bus_rdata_i = $urandom;
    stall = is_mem ? 6'b011111 : 6'b000011;
    settle;
    if (is_mem) m_mem_rd = exp_we ? m_mem_rd : exp_d; else m_if_rd = exp_d;
    sreq  = is_mem ? stallreq_mem_o : stallreq_if_o;
    got_d = is_mem ? mem_rdata_o : if_rdata_o;
    n_vec++;
    if ({bus_cyc_o, bus_timeout_o, sreq} !== {1'b0, tmo, 1'b0}) begin
      n_err++;
      $display("FAIL xfer_done: cyc%b timeout%b sreq%b expected cyc0 timeout%b sreq0",
               bus_cyc_o, bus_timeout_o, sreq, tmo);
    end
    if (!exp_we) begin
      n_vec++;
      if (got_d !== exp_d) begin
        n_err++; $display("FAIL xfer_rdata: %h expected %h", got_d, exp_d);
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick; settle;
      sreq  = is_mem ? stallreq_mem_o : stallreq_if_o;
      got_d = is_mem ? mem_rdata_o : if_rdata_o;
      n_vec++;
      if ({bus_cyc_o, bus_timeout_o, sreq} !== 3'b000 || (!exp_we && got_d !== exp_d)) begin
        n_err++;
        $display("FAIL xfer_hold: cyc%b to%b sreq%b data %h expected 000 data %h",
                 bus_cyc_o, bus_timeout_o, sreq, got_d, exp_d);
      end
    end
    tick; stall = 6'b0; settle;
    tick; settle;
    sreq = is_mem ? stallreq_mem_o : stallreq_if_o;
    n_vec++;
    if ({sreq, bus_cyc_o} !== 2'b10) begin
      n_err++; $display("FAIL xfer_consume: sreq/cyc=%b expected 10", {sreq, bus_cyc_o});
    end
    if_req_i = 0; mem_req_i = 0; mem_we_i = 0;
    tick; settle;
    n_vec++;
    if (bus_cyc_o !== 1'b0) begin
      n_err++; $display("FAIL xfer_reissue: cyc=%b expected 0", bus_cyc_o);
    end
  endtask

  task automatic test_reset;
    rst = 1; tick; tick;
    m_if_rd = 0; m_mem_rd = 0;
    n_vec++;
    if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
         if_rdata_o, mem_rdata_o, bus_timeout_o, stallreq_if_o, stallreq_mem_o} !== '0) begin
      n_err++; $display("FAIL reset: outputs not all zero (cyc%b addr%h)", bus_cyc_o, bus_addr_o);
    end
    rst = 0; tick;
  endtask

  task automatic test_fetch;
    run_xfer(0, 0, 4'h0, 32'h100, 32'h0, 32'h24010005, 2, 0);
  endtask

  task automatic test_simultaneous;
    stall = 0;
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h2000;
    if_req_i = 1; if_addr_i = 32'h104;
    settle;
    n_vec++;
    if ({stallreq_mem_o, stallreq_if_o} !== 2'b11) begin
      n_err++; $display("FAIL simul_req: %b expected 11", {stallreq_mem_o, stallreq_if_o});
    end
    tick; bus_ack_i = 1; bus_rdata_i = 32'h11223344; settle;
    n_vec++;
    if ({bus_cyc_o, bus_we_o, bus_addr_o} !== {1'b1, 1'b0, 32'h2000}) begin
      n_err++; $display("FAIL simul_data_first: cyc%b addr%h expected cyc1 addr 00002000", bus_cyc_o, bus_addr_o);
    end
    tick; bus_ack_i = 0; settle;
    m_mem_rd = 32'h11223344;
    n_vec++;
    if ({bus_cyc_o, stallreq_mem_o, stallreq_if_o, mem_rdata_o} !== {3'b001, m_mem_rd}) begin
      n_err++;
      $display("FAIL simul_idle: cyc%b sm%b si%b rdata %h expected 001 %h",
               bus_cyc_o, stallreq_mem_o, stallreq_if_o, mem_rdata_o, m_mem_rd);
    end
    mem_req_i = 0;
    tick; bus_ack_i = 1; bus_rdata_i = 32'h8C220000; settle;
    n_vec++;
    if ({bus_cyc_o, bus_sel_o, bus_addr_o, stallreq_if_o} !== {1'b1, 4'hF, 32'h104, 1'b1}) begin
      n_err++; $display("FAIL simul_fetch: cyc%b addr%h si%b expected 1 00000104 1", bus_cyc_o, bus_addr_o, stallreq_if_o);
    end
    tick; bus_ack_i = 0; settle;
    m_if_rd = 32'h8C220000;
    n_vec++;
    if ({bus_cyc_o, stallreq_if_o, if_rdata_o} !== {2'b00, m_if_rd}) begin
      n_err++; $display("FAIL simul_fetch_done: cyc%b si%b rdata %h expected 00 %h", bus_cyc_o, stallreq_if_o, if_rdata_o, m_if_rd);
    end
    if_req_i = 0; tick; tick;
  endtask

  task automatic test_hold_stall;
    run_xfer(0, 0, 4'h0, 32'h108, 32'h0, 32'hCAFEF00D, 1, 3);
  endtask

  task automatic test_flush_ibus;
    logic [31:0] prev;
    prev = m_if_rd;
    stall = 0; if_req_i = 1; if_addr_i = 32'h40; settle;
    tick; flush = 1; settle;
    n_vec++;
    if ({bus_cyc_o, stallreq_if_o, stallreq_mem_o} !== 3'b100) begin
      n_err++; $display("FAIL flush_cycle: cyc/si/sm=%b expected 100", {bus_cyc_o, stallreq_if_o, stallreq_mem_o});
    end
    tick; flush = 0; settle;
    n_vec++;
    if ({bus_cyc_o, bus_addr_o} !== {1'b1, 32'h40}) begin
      n_err++; $display("FAIL flush_hold_cyc: cyc%b addr%h expected 1 00000040", bus_cyc_o, bus_addr_o);
    end
    tick; bus_ack_i = 1; bus_rdata_i = 32'hBAD0BAD0; settle;
    n_vec++;
    if (bus_cyc_o !== 1'b1) begin
      n_err++; $display("FAIL flush_until_ack: cyc%b expected 1", bus_cyc_o);
    end
    tick; bus_ack_i = 0; if_addr_i = 32'h20; settle;
    n_vec++;
    if ({bus_cyc_o, stallreq_if_o, bus_timeout_o, if_rdata_o} !== {3'b010, prev}) begin
      n_err++; $display("FAIL flush_discard: cyc%b si%b to%b rdata %h expected 010 %h",
                        bus_cyc_o, stallreq_if_o, bus_timeout_o, if_rdata_o, prev);
    end
    tick; bus_ack_i = 1; bus_rdata_i = 32'h12345678; settle;
    n_vec++;
    if ({bus_cyc_o, bus_addr_o} !== {1'b1, 32'h20}) begin
      n_err++; $display("FAIL flush_refetch: cyc%b addr%h expected 1 00000020", bus_cyc_o, bus_addr_o);
    end
    tick; bus_ack_i = 0; settle;
    m_if_rd = 32'h12345678;
    n_vec++;
    if (if_rdata_o !== m_if_rd) begin
      n_err++; $display("FAIL flush_refetch_data: %h expected %h", if_rdata_o, m_if_rd);
    end
    tick; if_req_i = 0; tick;
  endtask

  task automatic test_store_flush;
    stall = 0;
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h3000; mem_wdata_i = 32'hDEADBEEF;
    settle;
    for (int k = 1; k <= 3; k++) begin
      tick;
      flush = (k == 1);
      bus_ack_i = (k == 3);
      settle;
      n_vec++;
      if ({bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !==
          {2'b11, 4'hF, 32'h3000, 32'hDEADBEEF}) begin
        n_err++; $display("FAIL store_flush_bus k=%0d: cyc%b we%b sel%h wdata%h", k, bus_cyc_o, bus_we_o, bus_sel_o, bus_wdata_o);
      end
    end
    tick; bus_ack_i = 0; settle;
    n_vec++;
    if ({bus_cyc_o, stallreq_mem_o} !== 2'b01) begin
      n_err++; $display("FAIL store_flush_valid: cyc/sm=%b expected 01", {bus_cyc_o, stallreq_mem_o});
    end
    mem_req_i = 0; mem_we_i = 0;
    tick; tick;
  endtask

  task automatic test_timeout;
    run_xfer(1, 0, 4'hF, 32'h5000, 32'h0, 32'h55AA55AA, 0, 0);
    run_xfer(0, 0, 4'h0, 32'h200, 32'h0, 32'h0F0F0F0F, 0, 1);
    // ack on the last allowed cycle beats the timeout
    run_xfer(1, 0, 4'h3, 32'h5004, 32'h0, 32'hA5A5A5A5, TO, 0);
  endtask

  task automatic test_reset_mid;
    stall = 0; if_req_i = 1; if_addr_i = 32'h60; settle;
    tick; tick; rst = 1; if_req_i = 0; settle;
    tick; rst = 0; bus_ack_i = 1; bus_rdata_i = 32'hFFFFFFFF; settle;
    m_if_rd = 0; m_mem_rd = 0;
    n_vec++;
    if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
         if_rdata_o, mem_rdata_o, bus_timeout_o} !== '0) begin
      n_err++; $display("FAIL reset_mid: cyc%b addr%h if_rdata%h", bus_cyc_o, bus_addr_o, if_rdata_o);
    end
    tick; bus_ack_i = 0; settle;
    n_vec++;
    if ({bus_cyc_o, if_rdata_o, mem_rdata_o} !== '0) begin
      n_err++; $display("FAIL reset_late_ack: cyc%b if_rdata%h mem_rdata%h", bus_cyc_o, if_rdata_o, mem_rdata_o);
    end
    tick;
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      run_xfer($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(1, 15)),
               $urandom, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    if_req_i = 0; if_addr_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_sel_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
    bus_rdata_i = 0; bus_ack_i = 0;
    m_if_rd = 0; m_mem_rd = 0;
    test_reset;
    test_fetch;
    test_simultaneous;
    test_hold_stall;
    test_flush_ibus;
    test_store_flush;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
